// File: rtl/width_arb_pkg.sv
// Shared types and sizes for the width round-robin arbiter.
package width_arb_pkg;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned SRC_W   = 2;

    typedef enum logic [SRC_W-1:0] {
        SRC_SINGLE = 2'd0,
        SRC_SMALL  = 2'd1,
        SRC_MEDIUM = 2'd2,
        SRC_BIG    = 2'd3
    } src_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/width_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import width_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               any
);

    logic [SRC_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = ptr + SRC_W'(i);
            if (!any && req[idx]) begin
                any          = 1'b1;
                gnt_idx      = idx;
                gnt[idx]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/width_rr_arbiter.sv
// Round-robin arbiter sharing one BIG_W output register among 1/8/64/128-bit requesters.
// Define ARB_STATS_EN to build the saturating per-source grant counters.
module width_rr_arbiter
    import width_arb_pkg::*;
#(
    parameter int unsigned SMALL_W  = 8,
    parameter int unsigned MEDIUM_W = 64,
    parameter int unsigned BIG_W    = 128,
    parameter int unsigned STATS_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       single_valid,
    input  logic                       single_data,
    output logic                       single_ready,
    input  logic                       small_valid,
    input  logic [SMALL_W-1:0]         small_data,
    output logic                       small_ready,
    input  logic                       medium_valid,
    input  logic [MEDIUM_W-1:0]        medium_data,
    output logic                       medium_ready,
    input  logic                       big_valid,
    input  logic [BIG_W-1:0]           big_data,
    output logic                       big_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BIG_W-1:0]           out_data,
    output logic [SRC_W-1:0]           out_src,
    output logic [NUM_SRC*STATS_W-1:0] grant_count
);

    out_state_e         state_q, state_d;
    logic [SRC_W-1:0]   rr_ptr;
    logic               load_en;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] gnt;
    logic [SRC_W-1:0]   gnt_idx;
    logic               grant;
    logic [BIG_W-1:0]   payload;

    assign out_valid = (state_q == ST_FULL);
    assign load_en   = !out_valid || out_ready;

    // Requests are masked while the output register cannot load or during reset.
    assign req = {big_valid, medium_valid, small_valid, single_valid}
               & {NUM_SRC{load_en && !reset}};

    rr_pick u_rr_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (grant)
    );

    assign {big_ready, medium_ready, small_ready, single_ready} = gnt;

    always_comb begin
        payload = '0;
        unique case (src_e'(gnt_idx))
            SRC_SINGLE: payload = BIG_W'(single_data);
            SRC_SMALL:  payload = BIG_W'(small_data);
            SRC_MEDIUM: payload = BIG_W'(medium_data);
            SRC_BIG:    payload = big_data;
            default:    payload = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A new grant refills the slot in the same edge it drains.
    always_comb begin
        state_d = state_q;
        if (grant) begin
            state_d = ST_FULL;
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            out_src  <= '0;
            rr_ptr   <= '0;
        end else if (grant) begin
            out_data <= payload;
            out_src  <= gnt_idx;
            rr_ptr   <= gnt_idx + SRC_W'(1);
        end
    end

`ifdef ARB_STATS_EN
    logic [STATS_W-1:0] grant_cnt [NUM_SRC];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                grant_cnt[i] <= '0;
            end
        end else if (grant && (grant_cnt[gnt_idx] != '1)) begin
            grant_cnt[gnt_idx] <= grant_cnt[gnt_idx] + STATS_W'(1);
        end
    end

    always_comb begin
        grant_count = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            grant_count[i*STATS_W +: STATS_W] = grant_cnt[i];
        end
    end
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_width_rr_arbiter.sv
// Directed bench for width_rr_arbiter: reset, single grant, round-robin, stall, reset mid-stall, stats.
module tb_width_rr_arbiter;

    localparam int unsigned SMALL_W  = 8;
    localparam int unsigned MEDIUM_W = 64;
    localparam int unsigned BIG_W    = 128;
    localparam int unsigned STATS_W  = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  single_valid, single_data, single_ready;
    logic                  small_valid, small_ready;
    logic [SMALL_W-1:0]    small_data;
    logic                  medium_valid, medium_ready;
    logic [MEDIUM_W-1:0]   medium_data;
    logic                  big_valid, big_ready;
    logic [BIG_W-1:0]      big_data;
    logic                  out_valid, out_ready;
    logic [BIG_W-1:0]      out_data;
    logic [1:0]            out_src;
    logic [4*STATS_W-1:0]  grant_count;

    int checks = 0;
    int errors = 0;

    width_rr_arbiter #(
        .SMALL_W  (SMALL_W),
        .MEDIUM_W (MEDIUM_W),
        .BIG_W    (BIG_W),
        .STATS_W  (STATS_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .single_valid (single_valid),
        .single_data  (single_data),
        .single_ready (single_ready),
        .small_valid  (small_valid),
        .small_data   (small_data),
        .small_ready  (small_ready),
        .medium_valid (medium_valid),
        .medium_data  (medium_data),
        .medium_ready (medium_ready),
        .big_valid    (big_valid),
        .big_data     (big_data),
        .big_ready    (big_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_src      (out_src),
        .grant_count  (grant_count)
    );

    always #5 clk = ~clk;

    // Requesters must hold valid and data until ready.
    a_single: assert property (@(posedge clk) disable iff (reset)
        (single_valid && !single_ready) |=> (single_valid && $stable(single_data)));
    a_small: assert property (@(posedge clk) disable iff (reset)
        (small_valid && !small_ready) |=> (small_valid && $stable(small_data)));
    a_medium: assert property (@(posedge clk) disable iff (reset)
        (medium_valid && !medium_ready) |=> (medium_valid && $stable(medium_data)));
    a_big: assert property (@(posedge clk) disable iff (reset)
        (big_valid && !big_ready) |=> (big_valid && $stable(big_data)));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] readies();
        return {big_ready, medium_ready, small_ready, single_ready};
    endfunction

    logic [127:0] exp_data [4];
    logic [1:0]   exp_src;

    initial begin
        exp_data[0] = 128'h1;
        exp_data[1] = 128'h80;
        exp_data[2] = 128'hDEAD_BEEF_0123_4567;
        exp_data[3] = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;

        // Reset with every requester valid
        reset        = 1'b1;
        out_ready    = 1'b1;
        single_valid = 1'b1; single_data = 1'b1;
        small_valid  = 1'b1; small_data  = 8'h80;
        medium_valid = 1'b1; medium_data = 64'hDEAD_BEEF_0123_4567;
        big_valid    = 1'b1; big_data    = exp_data[3];
        step();
        step();
        check("rst_ready", 128'(readies()), 128'h0);
        check("rst_valid", 128'(out_valid), 128'h0);
        check("rst_data", out_data, 128'h0);
        check("rst_count", 128'(grant_count), 128'h0);
        single_valid = 1'b0; small_valid = 1'b0; medium_valid = 1'b0; big_valid = 1'b0;
        step();
        reset = 1'b0;

        // Single small request
        small_valid = 1'b1;
        small_data  = 8'hA5;
        #1;
        check("single_ready", 128'(readies()), 128'h2);
        step();
        small_valid = 1'b0;
        small_data  = 8'h80;
        check("single_valid", 128'(out_valid), 128'h1);
        check("single_data", out_data, 128'hA5);
        check("single_src", 128'(out_src), 128'h1);

        // Re-reset to bring the pointer back to source 0
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Round-robin with everything valid; ends after a medium grant
        single_valid = 1'b1; small_valid = 1'b1; medium_valid = 1'b1; big_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp_src = 2'(i % 4);
            #1;
            check($sformatf("rr_ready%0d", i), 128'(readies()), 128'(4'b0001 << exp_src));
            step();
            check($sformatf("rr_src%0d", i), 128'(out_src), 128'(exp_src));
            check($sformatf("rr_data%0d", i), out_data, exp_data[exp_src]);
        end

        // Backpressure holding the medium payload
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall_ready%0d", i), 128'(readies()), 128'h0);
            step();
            check($sformatf("stall_data%0d", i), out_data, 128'hDEAD_BEEF_0123_4567);
            check($sformatf("stall_src%0d", i), 128'(out_src), 128'h2);
            check($sformatf("stall_valid%0d", i), 128'(out_valid), 128'h1);
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", 128'(readies()), 128'h8);
        step();
        check("release_data", out_data, exp_data[3]);
        check("release_src", 128'(out_src), 128'h3);

        // Grant single so the pointer sits at 1, then stall and reset
        #1;
        check("pre_ready", 128'(readies()), 128'h1);
        step();
        check("pre_src", 128'(out_src), 128'h0);
        out_ready = 1'b0;
        step();
        step();
        check("midstall_valid", 128'(out_valid), 128'h1);
        reset     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("inreset_ready", 128'(readies()), 128'h0);
        step();
        reset = 1'b0;
        check("postrst_valid", 128'(out_valid), 128'h0);
        check("postrst_data", out_data, 128'h0);
        check("postrst_src", 128'(out_src), 128'h0);
        #1;
        check("postrst_ready", 128'(readies()), 128'h1);
        step();
        check("postrst_gsrc", 128'(out_src), 128'h0);
        check("postrst_gdata", out_data, 128'h1);

        // Twenty back-to-back big-only grants
        reset = 1'b1;
        single_valid = 1'b0; small_valid = 1'b0; medium_valid = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("bigonly_ready%0d", i), 128'(readies()), 128'h8);
            step();
        end
        check("bigonly_src", 128'(out_src), 128'h3);
`ifdef ARB_STATS_EN
        check("count_big", 128'(grant_count[15:12]), 128'hF);
        check("count_rest", 128'(grant_count[11:0]), 128'h0);
`else
        check("count_tied", 128'(grant_count), 128'h0);
`endif
        big_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
